// File: rtl/fetch_unit_if.sv
// Instruction-memory read port shared by the fetch unit (master) and memory (slave).
// A request is held until a one-cycle acknowledge strobe returns the read data.
interface fetch_unit_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
    modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/fetch_unit.sv
// Single-entry instruction prefetcher: fetches the word at pc into a buffer and
// hands it to the instruction register when the control unit asks for it.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 32'd15
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master mem,
    input  logic         i_pc_write,
    input  logic [15:0]  i_pc_next,
    input  logic         i_ir_wr,
    output logic [15:0]  o_pc,
    output logic [15:0]  o_old_pc,
    output logic [15:0]  o_instruction,
    output logic         o_stall,
    output logic         o_fetch_err
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 32'd1);
    localparam logic [3:0] TMO_VAL  = 4'(TIMEOUT);

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_old_pc;
    logic [15:0] r_instr;
    logic [15:0] r_buf;
    logic [3:0]  r_cnt;
    logic        r_err;
    logic        r_mem_req;
    logic        r_rst_done;

    state_t      w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_buf_ld;
    logic        w_err_set;
    logic        w_tmo;
    logic        w_req_nxt;
    logic        w_ir_ld;

    // Next-state, timeout counter and buffer-capture decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_buf_ld    = 1'b0;
        w_err_set   = 1'b0;
        w_tmo       = (r_cnt == TMO_LAST);
        case (r_state)
            S_EMPTY: begin
                // The first edge after reset release only arms the unit
                if (i_pc_write) begin
                    w_state_nxt = S_EMPTY;
                end else if (r_rst_done) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_BUSY: begin
                if (mem.mem_ack) begin
                    if (i_pc_write) begin
                        w_state_nxt = S_EMPTY;
                    end else begin
                        w_state_nxt = S_FULL;
                        w_buf_ld    = 1'b1;
                    end
                end else if (w_tmo) begin
                    w_state_nxt = S_EMPTY;
                    w_err_set   = 1'b1;
                    w_cnt_nxt   = TMO_VAL;
                end else if (i_pc_write) begin
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            S_FLUSH: begin
                // The outstanding read belongs to a stale pc; drop its data
                if (mem.mem_ack) begin
                    w_state_nxt = S_EMPTY;
                end else if (w_tmo) begin
                    w_state_nxt = S_EMPTY;
                    w_err_set   = 1'b1;
                    w_cnt_nxt   = TMO_VAL;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            S_FULL: begin
                if (i_pc_write) begin
                    w_state_nxt = S_EMPTY;
                end else begin
                    w_state_nxt = S_FULL;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
                w_cnt_nxt   = 4'd0;
            end
        endcase
        w_req_nxt = (w_state_nxt == S_BUSY) || (w_state_nxt == S_FLUSH);
        w_ir_ld   = i_ir_wr && (r_state == S_FULL);
    end

    // State, pc, instruction register and sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_EMPTY;
            r_pc       <= RESET_PC;
            r_old_pc   <= 16'h0000;
            r_instr    <= 16'h0000;
            r_buf      <= 16'h0000;
            r_cnt      <= 4'd0;
            r_err      <= 1'b0;
            r_mem_req  <= 1'b0;
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mem_req  <= w_req_nxt;
            if (w_buf_ld) begin
                r_buf <= mem.mem_rdata;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (i_pc_write) begin
                r_pc <= i_pc_next;
            end
            // old_pc takes the pre-update pc even when pc_write hits the same edge
            if (w_ir_ld) begin
                r_instr  <= r_buf;
                r_old_pc <= r_pc;
            end
        end
    end

    assign mem.mem_req    = r_mem_req;
    assign mem.mem_addr   = r_pc;
    assign o_pc           = r_pc;
    assign o_old_pc       = r_old_pc;
    assign o_instruction  = r_instr;
    assign o_fetch_err    = r_err;
    assign o_stall        = i_ir_wr && (r_state != S_FULL);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded by reset.
REQ-002 Parameter TIMEOUT, default 15, max BUSY/FLUSH cycles without mem_ack (4-bit counter).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 pc_write  input  1  from control unit; load pc from pc_next.
REQ-006 pc_next  input  16  new PC value (ALU/result bus).
REQ-007 ir_wr  input  1  from control unit; latch fetched instruction.
REQ-008 mem_req  output  1  instruction-memory read request.
REQ-009 mem_addr  output  16  read address, equals pc while mem_req=1.
REQ-010 mem_rdata  input  16  read data, valid with mem_ack.
REQ-011 mem_ack  input  1  one-cycle read completion strobe.
REQ-012 pc  output  16  current program counter.
REQ-013 old_pc  output  16  PC of the instruction held in instruction.
REQ-014 instruction  output  16  instruction register, feeds control unit and datapath.
REQ-015 stall  output  1  combinational; top level holds control-unit state while 1.
REQ-016 fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-017 FSM states SHALL be EMPTY, BUSY, FULL, FLUSH; 16-bit prefetch buffer holds data for pc when FULL.
REQ-018 EMPTY SHALL go to BUSY next cycle; mem_req=1 exactly in BUSY and FLUSH.
REQ-019 mem_addr SHALL hold pc stable for the whole BUSY request.
REQ-020 BUSY with mem_ack SHALL capture mem_rdata into buffer and go FULL; mem_req=0 from next cycle.
REQ-021 FLUSH with mem_ack SHALL discard mem_rdata and go EMPTY.
REQ-022 mem_ack in EMPTY or FULL SHALL be ignored.
REQ-023 stall SHALL equal ir_wr AND (state != FULL).
REQ-024 ir_wr in FULL SHALL load instruction<=buffer, old_pc<=pc; state stays FULL.
REQ-025 ir_wr while stalled SHALL leave instruction and old_pc unchanged.
REQ-026 pc_write SHALL load pc<=pc_next in any state.
REQ-027 pc_write in FULL or EMPTY SHALL go EMPTY; in BUSY SHALL go FLUSH; in FLUSH stays FLUSH.
REQ-028 pc_write and mem_ack same cycle in BUSY SHALL go EMPTY, data discarded.
REQ-029 ir_wr and pc_write same cycle in FULL: instruction<=buffer, old_pc<=old pc value, pc<=pc_next, state EMPTY.
REQ-030 Timeout counter SHALL clear on entry to BUSY/FLUSH, increment each BUSY/FLUSH cycle without mem_ack.
REQ-031 Counter reaching TIMEOUT SHALL set fetch_err=1, drop mem_req next cycle, go EMPTY (retry at current pc).
REQ-032 fetch_err SHALL clear only by reset.
REQ-033 pc arithmetic is external; block never increments pc.

Reset
REQ-034 reset=0 SHALL immediately force pc=RESET_PC, old_pc=0, instruction=0, buffer=0, state EMPTY, mem_req=0, fetch_err=0, counter=0.
REQ-035 Reset mid-request SHALL abandon request; late mem_ack after release SHALL be ignored (state EMPTY).
REQ-036 First mem_req SHALL rise on the second rising edge after reset release.

Verification
REQ-037 Release reset, ack after 3 wait cycles with 16'h1234 -> mem_addr=0000, state FULL; ir_wr -> instruction=1234, old_pc=0000, stall=0.
REQ-038 ir_wr asserted during BUSY -> stall=1 until ack cycle+1, then instruction loaded, no earlier change.
REQ-039 pc_write pc_next=0040 during BUSY, then ack 16'hDEAD -> data discarded, new request mem_addr=0040.
REQ-040 FULL, ir_wr+pc_write pc_next=0002 same cycle -> instruction=buffer, old_pc=0000, pc=0002, next mem_addr=0002.
REQ-041 No ack for 15 BUSY cycles -> fetch_err=1, mem_req drops one cycle, retries same address; fetch_err stays 1 after later ack.
REQ-042 reset=0 asserted mid-BUSY between edges -> outputs reset values immediately, stray ack ignored.
